// File: rtl/poly_synthesizer_pkg.sv
// poly_synthesizer_pkg: shared types, envelope width and envelope step helper
package poly_synthesizer_pkg;
  localparam int ENV_BITS = 8;
  localparam int CFG_PHASE_BITS = 32;
  typedef enum logic [2:0] {
    WAVE_OFF    = 3'd0,
    WAVE_SAW    = 3'd1,
    WAVE_SQUARE = 3'd2,
    WAVE_TRI    = 3'd3,
    WAVE_SINE   = 3'd4
  } wave_t;
  // wave is kept as raw bits so codes 5..7 stay legal and simply decode as off
  typedef struct packed {
    logic [CFG_PHASE_BITS-1:0] incr;
    logic [2:0]                wave;
    logic                      gate;
  } voice_cfg_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, OUT} state_t;
  function automatic logic [ENV_BITS-1:0] env_step(logic [ENV_BITS-1:0] l, logic gate, int up, int dn);
    int s;
    s = gate ? int'(l) + up : int'(l) - dn;
    return s > (1 << ENV_BITS) - 1 ? {ENV_BITS{1'b1}} : s < 0 ? '0 : ENV_BITS'(s);
  endfunction
endpackage

// File: rtl/poly_synthesizer_sine_lut.sv
// poly_synthesizer_sine_lut: synchronous-read quarter-wave sine ROM, one cycle latency
//   clk_in: clock; addr: quarter-wave index; data: unsigned magnitude, full scale 2^DATA_BITS-1
module poly_synthesizer_sine_lut #(
  parameter int LUT_BITS  = 8,
  parameter int DATA_BITS = 23
) (
  input  logic                 clk_in,
  input  logic [LUT_BITS-1:0]  addr,
  output logic [DATA_BITS-1:0] data
);
  // half-step offset makes the table mirror exactly when addressed with ~addr
  function automatic logic [DATA_BITS-1:0] sine_at(int i);
    real x;
    x = 1.5707963267948966 * (real'(i) + 0.5) / real'(2 ** LUT_BITS);
    return DATA_BITS'($rtoi((2.0 ** DATA_BITS - 1.0) * $sin(x) + 0.5));
  endfunction
  logic [DATA_BITS-1:0] rom [2 ** LUT_BITS];
  for (genvar i = 0; i < 2 ** LUT_BITS; i++) begin : g_rom
    assign rom[i] = sine_at(i);
  end
  always_ff @(posedge clk_in) data <= rom[addr];
endmodule

// File: rtl/poly_synthesizer.sv
// poly_synthesizer: time-multiplexed multi-voice DDS synthesizer with envelopes and saturating mix
//   clk_in, n_rst_in: clock and asynchronous active-low reset
//   sample_tick_in: frame request; busy_out: frame in progress; overrun_out: sticky tick-while-busy
//   cfg_valid_in/cfg_voice_in/cfg_phase_incr_in/cfg_wave_in/cfg_gate_in: shadow config write
//   sample_out/sample_valid_out: mixed signed sample, updated with a one-cycle strobe
module poly_synthesizer
  import poly_synthesizer_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int PHASE_BITS   = 32,
  parameter int OUT_WIDTH    = 24,
  parameter int LUT_BITS     = 8,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4,
  parameter int MIX_SHIFT    = 2,
  localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        clk_in,
  input  logic                        n_rst_in,
  input  logic                        sample_tick_in,
  input  logic                        cfg_valid_in,
  input  logic [VW-1:0]               cfg_voice_in,
  input  logic [PHASE_BITS-1:0]       cfg_phase_incr_in,
  input  logic [2:0]                  cfg_wave_in,
  input  logic                        cfg_gate_in,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        sample_valid_out,
  output logic                        busy_out,
  output logic                        overrun_out
);
  localparam int OW = OUT_WIDTH;
  localparam int PB = PHASE_BITS;
  localparam int AW = OW + $clog2(NUM_VOICES) + 1;
  localparam logic signed [OW-1:0] MAX_S = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MIN_S = {1'b1, {(OW-1){1'b0}}};
  state_t state;
  logic [VW-1:0] vidx;
  logic drn;
  voice_cfg_t shadow [NUM_VOICES];
  voice_cfg_t active [NUM_VOICES];
  logic [PB-1:0] phase [NUM_VOICES];
  logic [ENV_BITS-1:0] level [NUM_VOICES];
  logic [LUT_BITS-1:0] lut_addr;
  logic [OW-2:0] lut_data;
  // stage 1 keeps only the phase bits the waveforms need: top OW for saw, one more for the triangle ramp
  logic s1_valid;
  logic [OW:0] s1_ph;
  logic [2:0] s1_wave;
  logic [ENV_BITS-1:0] s1_level;
  logic s2_valid;
  logic signed [OW-1:0] s2_voice;
  logic signed [AW-1:0] acc, acc_next, mixed;
  logic [1:0] quad;
  logic signed [OW-1:0] ramp, sine_s, wave_s, sat;
  logic signed [OW+8:0] prod;
  // odd quadrants read the quarter table backwards
  assign lut_addr = phase[vidx][PB-2] ? ~phase[vidx][PB-3 -: LUT_BITS] : phase[vidx][PB-3 -: LUT_BITS];
  poly_synthesizer_sine_lut #(.LUT_BITS(LUT_BITS), .DATA_BITS(OW-1)) u_sine_lut (
    .clk_in(clk_in),
    .addr  (lut_addr),
    .data  (lut_data)
  );
  always_comb begin
    quad = s1_ph[OW:OW-1];
    ramp = $signed({1'b0, s1_ph[OW-2:0]});
    sine_s = $signed({1'b0, lut_data});
    wave_s = s1_wave == WAVE_SAW ? $signed({~s1_ph[OW], s1_ph[OW-1:1]})
           : s1_wave == WAVE_SQUARE ? (s1_ph[OW] ? -MAX_S : MAX_S)
           : s1_wave == WAVE_TRI ? (quad == 2'd0 ? ramp : quad == 2'd1 ? MAX_S - ramp : quad == 2'd2 ? -ramp : ramp - MAX_S)
           : s1_wave == WAVE_SINE ? (s1_ph[OW] ? -sine_s : sine_s)
           : '0;
    prod = (OW+9)'(wave_s) * (OW+9)'($signed({1'b0, s1_level}));
  end
  always_comb begin
    acc_next = acc + (s2_valid ? AW'(s2_voice) : '0);
    mixed = acc_next >>> MIX_SHIFT;
    sat = mixed > AW'(MAX_S) ? MAX_S : mixed < AW'(MIN_S) ? MIN_S : OW'(mixed);
  end
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        shadow[v] <= '0;
        active[v] <= '0;
        phase[v] <= '0;
        level[v] <= '0;
      end
      s1_valid <= 1'b0;
      s1_ph <= '0;
      s1_wave <= '0;
      s1_level <= '0;
      s2_valid <= 1'b0;
      s2_voice <= '0;
      acc <= '0;
    end else begin
      if (cfg_valid_in) shadow[cfg_voice_in] <= '{incr: CFG_PHASE_BITS'(cfg_phase_incr_in), wave: cfg_wave_in, gate: cfg_gate_in};
      if (state == IDLE && sample_tick_in) begin
        active <= shadow;
        acc <= '0;
      end else acc <= acc_next;
      s1_valid <= state == SWEEP;
      if (state == SWEEP) begin
        s1_ph <= phase[vidx][PB-1 -: OW+1];
        s1_wave <= active[vidx].wave;
        s1_level <= level[vidx];
        phase[vidx] <= phase[vidx] + PB'(active[vidx].incr);
        level[vidx] <= env_step(level[vidx], active[vidx].gate, ATTACK_STEP, RELEASE_STEP);
      end
      s2_valid <= s1_valid;
      s2_voice <= OW'(prod >>> 8);
    end
  end
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      state <= IDLE;
      vidx <= '0;
      drn <= 1'b0;
      sample_out <= '0;
      sample_valid_out <= 1'b0;
      busy_out <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      if (sample_tick_in && state != IDLE) overrun_out <= 1'b1;
      case (state)
        IDLE: if (sample_tick_in) begin
          state <= SWEEP;
          vidx <= '0;
          busy_out <= 1'b1;
        end
        SWEEP: if (vidx == VW'(NUM_VOICES - 1)) begin
          state <= DRAIN;
          drn <= 1'b0;
        end else vidx <= vidx + 1'b1;
        DRAIN: begin
          drn <= 1'b1;
          if (drn) begin
            state <= OUT;
            sample_out <= sat;
            sample_valid_out <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_poly_synthesizer.sv
// tb_poly_synthesizer: directed and randomized frames checked against an arithmetic voice model
module tb_poly_synthesizer;
  localparam int N = 4, PB = 32, OW = 24, LB = 8, AS = 255, RS = 4, MS = 0;
  localparam longint MAXV = (longint'(1) <<< (OW - 1)) - 1;
  logic clk = 1'b0, n_rst = 1'b0, tick = 1'b0, cfg_valid = 1'b0, cfg_gate = 1'b0;
  logic [1:0] cfg_voice = '0;
  logic [PB-1:0] cfg_incr = '0;
  logic [2:0] cfg_wave = '0;
  logic signed [OW-1:0] sample;
  logic valid, busy, overrun;
  int errs = 0, checks = 0;
  longint unsigned m_phase [N], sh_incr [N], ac_incr [N];
  int m_level [N], sh_wave [N], ac_wave [N];
  bit sh_gate [N], ac_gate [N];
  longint last = 0;
  bit exp_ovr = 0;

  poly_synthesizer #(.NUM_VOICES(N), .PHASE_BITS(PB), .OUT_WIDTH(OW), .LUT_BITS(LB),
    .ATTACK_STEP(AS), .RELEASE_STEP(RS), .MIX_SHIFT(MS)) dut (
    .clk_in(clk), .n_rst_in(n_rst), .sample_tick_in(tick), .cfg_valid_in(cfg_valid),
    .cfg_voice_in(cfg_voice), .cfg_phase_incr_in(cfg_incr), .cfg_wave_in(cfg_wave),
    .cfg_gate_in(cfg_gate), .sample_out(sample), .sample_valid_out(valid),
    .busy_out(busy), .overrun_out(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint lutv(int i);
    return longint'($rtoi(real'(MAXV) * $sin(1.5707963267948966 * (real'(i) + 0.5) / 256.0) + 0.5));
  endfunction

  function automatic longint wave_val(longint unsigned ph, int w);
    longint q = longint'(ph >> (PB - 2));
    longint r = longint'((ph >> (PB - 2 - (OW - 1))) & MAXV);
    int a = int'((ph >> (PB - 2 - LB)) & 255);
    case (w)
      1: return longint'(ph >> (PB - OW)) - (MAXV + 1);
      2: return q < 2 ? MAXV : -MAXV;
      3: return q == 0 ? r : q == 1 ? MAXV - r : q == 2 ? -r : r - MAXV;
      4: return (q % 2 == 0 ? lutv(a) : lutv(255 - a)) * (q < 2 ? 1 : -1);
      default: return 0;
    endcase
  endfunction

  task automatic model_frame(output longint e);
    longint s = 0;
    for (int v = 0; v < N; v++) begin
      ac_incr[v] = sh_incr[v];
      ac_wave[v] = sh_wave[v];
      ac_gate[v] = sh_gate[v];
    end
    for (int v = 0; v < N; v++) begin
      s += (wave_val(m_phase[v], ac_wave[v]) * m_level[v]) >>> 8;
      m_phase[v] = (m_phase[v] + ac_incr[v]) % (64'd1 << PB);
      m_level[v] = ac_gate[v] ? (m_level[v] + AS > 255 ? 255 : m_level[v] + AS)
                              : (m_level[v] - RS < 0 ? 0 : m_level[v] - RS);
    end
    s = s >>> MS;
    e = s > MAXV ? MAXV : s < -MAXV - 1 ? -MAXV - 1 : s;
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = 0; m_level[v] = 0; sh_incr[v] = 0; sh_wave[v] = 0; sh_gate[v] = 0;
    end
    last = 0;
    exp_ovr = 0;
  endtask

  task automatic drive_cfg(input logic [1:0] v, input logic [PB-1:0] i, input logic [2:0] w, input logic g);
    cfg_valid = 1'b1; cfg_voice = v; cfg_incr = i; cfg_wave = w; cfg_gate = g;
  endtask

  task automatic apply_shadow(input logic [1:0] v, input logic [PB-1:0] i, input logic [2:0] w, input logic g);
    sh_incr[v] = i; sh_wave[v] = int'(w); sh_gate[v] = g;
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [PB-1:0] i, input logic [2:0] w, input logic g);
    drive_cfg(v, i, w, g);
    @(posedge clk); #1 cfg_valid = 1'b0;
    apply_shadow(v, i, w, g);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  // mode 0: plain tick, 1: cfg write on the tick cycle, 2: cfg write during the sweep
  task automatic run_frame(input int mode, input logic [1:0] v, input logic [PB-1:0] i, input logic [2:0] w, input logic g);
    longint e;
    int n;
    model_frame(e);
    if (mode == 1) drive_cfg(v, i, w, g);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    cfg_valid = 1'b0;
    if (mode == 1) apply_shadow(v, i, w, g);
    n = 1;
    if (mode == 2) drive_cfg(v, i, w, g);
    check("busy_rise", busy, 1);
    while (valid !== 1'b1 && n < N + 10) begin
      @(posedge clk); #1 cfg_valid = 1'b0;
      n++;
    end
    if (mode == 2) apply_shadow(v, i, w, g);
    check("latency", n, N + 3);
    check("sample", sample, e);
    check("busy_valid", busy, 1);
    last = e;
    @(posedge clk); #1;
    check("valid_drop", valid, 0);
    check("busy_drop", busy, 0);
    check("overrun", overrun, exp_ovr);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      check("hold", sample, last);
    end
  endtask

  initial begin
    longint e;
    int pulses;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sample", sample, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    n_rst = 1'b1;
    idle(2);

    // saw ramp on voice 0
    cfg_write(2'd0, 32'h1000_0000, 3'd1, 1'b1);
    run_frame(0, 0, 0, 0, 0);
    check("saw_first", sample, 0);
    for (int k = 0; k < 39; k++) begin
      run_frame(0, 0, 0, 0, 0);
      idle($urandom_range(0, 3));
    end

    // square saturation with four aligned voices
    do_reset();
    for (int v = 0; v < N; v++) cfg_write(2'(v), 32'h1000_0000, 3'd2, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      run_frame(0, 0, 0, 0, 0);
      if (k == 2) check("sq_pos", sample, MAXV);
      if (k == 10) check("sq_neg", sample, -MAXV - 1);
    end

    // release from full level on voice 0 alone
    cfg_write(2'd0, 32'h1000_0000, 3'd2, 1'b0);
    for (int v = 1; v < N; v++) cfg_write(2'(v), 32'h0, 3'd0, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      run_frame(0, 0, 0, 0, 0);
      if (k > 64) check("rel_zero", sample, 0);
    end

    // config during sweep and on the tick cycle lands in the shadows only
    cfg_write(2'd1, 32'h0300_0000, 3'd1, 1'b1);
    run_frame(0, 0, 0, 0, 0);
    run_frame(2, 2'd1, 32'h0700_0000, 3'd3, 1'b1);
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 2'd1, 32'h0123_4567, 3'd4, 1'b1);
    run_frame(2, 2'd1, 32'h0020_0000, 3'd2, 1'b0);
    run_frame(0, 0, 0, 0, 0);

    // randomized voices, waves and config timing
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(2'($urandom_range(0, N - 1)), $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      run_frame($urandom_range(0, 2), 2'($urandom_range(0, N - 1)), $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    // overrun: second tick two cycles after the first
    model_frame(e);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk); #1;
    check("ovr_pre", overrun, 0);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    check("ovr_rise", overrun, 1);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        pulses++;
        check("ovr_sample", sample, e);
      end
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_sticky", overrun, 1);
    last = e;
    exp_ovr = 1;
    run_frame(0, 0, 0, 0, 0);

    // reset asserted mid-sweep
    model_frame(e);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk); #2 n_rst = 1'b0;
    #1;
    check("mid_rst_sample", sample, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    run_frame(0, 0, 0, 0, 0);
    check("post_rst_zero", sample, 0);
    cfg_write(2'd0, 32'h1000_0000, 3'd1, 1'b1);
    for (int k = 0; k < 4; k++) run_frame(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
